mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sequences one outstanding transaction at a time over a req/gnt/rvalid bus, and returns read data to the owning requester.
- Generates the per-requester stall signals that feed the pipeline hazard controller's IF-RAM and MEM-RAM stall inputs.
- Discards fetch responses made stale by a pipeline flush, and recovers from a hung bus via a watchdog.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_watchdog.sv | 35 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM memory-port arbiter.
// Imported by the arbiter top and its watchdog sub-module.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Width needed to hold counts 0 .. limit-1 (never narrower than one bit).
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Bus watchdog: counts cycles spent in a transaction and pulses expire
// on the TIMEOUT-th active cycle; TIMEOUT = 0 disables it.
module bus_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam int                CNT_W = cnt_width(TIMEOUT);
    localparam bit                WD_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  TERM  = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;

    // The counter holds at the terminal value; the arbiter leaves the
    // transaction in that same cycle, so it never needs to wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (active && (cnt_q != TERM)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = WD_EN && active && (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time over a req/gnt/rvalid bus.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; pick MEM over IF and latch its request fields
// ADDR    | bus_req_o held with latched fields until bus_gnt_i
// RESP    | waiting for bus_rvalid_i; result routed to the owner
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_rvalid_o,
    output logic                if_stall_o,

    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_rvalid_o,
    output logic                mem_stall_o,

    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,

    output logic                timeout_o
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q, state_d;
    owner_t              owner_q;
    logic                drop_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                timeout_q;

    logic                mem_win;
    logic                if_win;
    logic                start;
    logic                in_txn;
    logic                wd_expire;
    logic                complete;
    logic                abort;
    logic                finish;
    logic [DATA_W-1:0]   resp_data;

    assign mem_win = (state_q == ST_IDLE) && mem_req_i;
    assign if_win  = (state_q == ST_IDLE) && !mem_req_i && if_req_i && !if_flush_i;
    assign start   = mem_win || if_win;
    assign in_txn  = (state_q != ST_IDLE);

    // A real response beats the watchdog if both land in the same cycle.
    assign complete  = (state_q == ST_RESP) && bus_rvalid_i;
    assign abort     = wd_expire && !complete;
    assign finish    = complete || abort;
    assign resp_data = complete ? bus_rdata_i : '0;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .active (in_txn),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (wd_expire)      state_d = ST_IDLE;
                else if (bus_gnt_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (finish) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so the bus sees stable values
    // even if the requester changes its inputs while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_IF;
            drop_q    <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start) begin
                owner_q <= mem_win ? OWN_MEM : OWN_IF;
                drop_q  <= 1'b0;
                addr_q  <= mem_win ? mem_addr_i : if_addr_i;
                we_q    <= mem_win && mem_we_i;
                wdata_q <= mem_win ? mem_wdata_i : '0;
                wstrb_q <= mem_win ? mem_wstrb_i : '0;
            end else if (in_txn && (owner_q == OWN_IF) && if_flush_i) begin
                drop_q  <= 1'b1;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = '0;
        bus_wdata_o  = '0;
        bus_wstrb_o  = '0;
        if_rvalid_o  = 1'b0;
        if_rdata_o   = '0;
        mem_rvalid_o = 1'b0;
        mem_rdata_o  = '0;

        if (state_q == ST_ADDR) begin
            bus_req_o   = 1'b1;
            bus_we_o    = we_q;
            bus_addr_o  = addr_q;
            bus_wdata_o = wdata_q;
            bus_wstrb_o = wstrb_q;
        end

        // A fetch flushed now or earlier is consumed without a pulse.
        if (finish) begin
            if (owner_q == OWN_MEM) begin
                mem_rvalid_o = 1'b1;
                mem_rdata_o  = resp_data;
            end else if (!drop_q && !if_flush_i) begin
                if_rvalid_o  = 1'b1;
                if_rdata_o   = resp_data;
            end
        end
    end

    assign if_stall_o  = if_req_i && !if_rvalid_o;
    assign mem_stall_o = mem_req_i && !mem_rvalid_o;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; a transaction tracker
// predicts bus, completion, stall and watchdog behaviour every cycle.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, if_flush_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_rvalid_o, if_stall_o;
    logic          mem_req_i, mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [SW-1:0] mem_wstrb_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_rvalid_o, mem_stall_o;
    logic          bus_req_o, bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic [SW-1:0] bus_wstrb_o;
    logic          bus_gnt_i, bus_rvalid_i;
    logic [DW-1:0] bus_rdata_i;
    logic          timeout_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o), .if_stall_o(if_stall_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o), .mem_rvalid_o(mem_rvalid_o), .mem_stall_o(mem_stall_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference: the one transaction in flight, as seen from outside.
    bit            t_busy, t_granted, t_own_mem, t_drop, t_sticky_to;
    int            t_age;
    logic [AW-1:0] t_addr;
    logic          t_we;
    logic [DW-1:0] t_wdata;
    logic [SW-1:0] t_wstrb;

    logic          o_if_rv, o_mem_rv, o_bus_req, o_bus_we, o_if_stall, o_to;
    logic [31:0]   o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata;
    bit            last_if_rv, last_mem_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    endtask

    // Called just after a negedge with inputs set; checks, then advances one clock.
    task automatic cycle();
        bit            fin, abrt, e_req, e_if_rv, e_mem_rv;
        logic [DW-1:0] e_data;
        fin = 0; abrt = 0; e_req = 0; e_if_rv = 0; e_mem_rv = 0; e_data = '0;
        #1;
        o_if_rv = if_rvalid_o;   o_mem_rv = mem_rvalid_o;  o_bus_req = bus_req_o;
        o_bus_we = bus_we_o;     o_if_stall = if_stall_o;  o_to = timeout_o;
        o_if_rdata = if_rdata_o; o_mem_rdata = mem_rdata_o;
        o_bus_addr = bus_addr_o; o_bus_wdata = bus_wdata_o;
        if (rst) begin
            e_req    = t_busy && !t_granted;
            fin      = t_busy && t_granted && bus_rvalid_i;
            abrt     = t_busy && !fin && (t_age == TMO - 1);
            e_data   = fin ? bus_rdata_i : '0;
            e_mem_rv = (fin || abrt) && t_own_mem;
            e_if_rv  = (fin || abrt) && !t_own_mem && !t_drop && !if_flush_i;
        end
        chk("bus_req", 32'(o_bus_req), 32'(e_req));
        if (e_req) begin
            chk("bus_addr", o_bus_addr, t_addr);
            chk("bus_we", 32'(o_bus_we), 32'(t_we));
            if (t_own_mem) begin
                chk("bus_wdata", o_bus_wdata, t_wdata);
                chk("bus_wstrb", 32'(bus_wstrb_o), 32'(t_wstrb));
            end
        end
        chk("if_rvalid", 32'(o_if_rv), 32'(e_if_rv));
        chk("mem_rvalid", 32'(o_mem_rv), 32'(e_mem_rv));
        chk("if_rdata", o_if_rdata, e_if_rv ? e_data : '0);
        chk("mem_rdata", o_mem_rdata, e_mem_rv ? e_data : '0);
        chk("if_stall", 32'(o_if_stall), 32'(if_req_i && !e_if_rv));
        chk("mem_stall", 32'(mem_stall_o), 32'(mem_req_i && !e_mem_rv));
        chk("timeout", 32'(o_to), 32'(rst && t_sticky_to));
        last_if_rv = e_if_rv;
        last_mem_rv = e_mem_rv;

        if (!rst) begin
            t_busy = 0; t_drop = 0; t_sticky_to = 0; t_age = 0; t_granted = 0;
        end else if (!t_busy) begin
            if (mem_req_i || (if_req_i && !if_flush_i)) begin
                t_busy = 1; t_granted = 0; t_drop = 0; t_age = 0;
                t_own_mem = mem_req_i;
                t_addr  = mem_req_i ? mem_addr_i : if_addr_i;
                t_we    = mem_req_i && mem_we_i;
                t_wdata = mem_wdata_i;
                t_wstrb = mem_wstrb_i;
            end
        end else if (fin || abrt) begin
            t_busy = 0;
            if (abrt) t_sticky_to = 1;
        end else begin
            if (!t_own_mem && if_flush_i) t_drop = 1;
            if (!t_granted && bus_gnt_i) t_granted = 1;
            t_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        t_busy = 0; t_granted = 0; t_own_mem = 0; t_drop = 0; t_sticky_to = 0; t_age = 0;
        t_addr = '0; t_we = 0; t_wdata = '0; t_wstrb = '0;
        @(negedge clk);
        cycle();
        chk("rst_bus_req", 32'(o_bus_req), 32'd0);
        cycle();
        rst = 1;
        cycle();

        // 1: single fetch, gnt immediate, data on the following cycle
        if_req_i = 1; if_addr_i = 32'h8000_0000;
        cycle();
        chk("t1_stall_c1", 32'(o_if_stall), 32'd1);
        bus_gnt_i = 1;
        cycle();
        chk("t1_stall_c2", 32'(o_if_stall), 32'd1);
        chk("t1_addr", o_bus_addr, 32'h8000_0000);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_0413;
        cycle();
        chk("t1_rvalid", 32'(o_if_rv), 32'd1);
        chk("t1_rdata", o_if_rdata, 32'h0000_0413);
        if_req_i = 0; bus_rvalid_i = 0;
        cycle();

        // 2: simultaneous requests, MEM store wins
        if_req_i = 1; if_addr_i = 32'h8000_0004;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h8000_1000;
        mem_wdata_i = 32'hDEAD_BEEF; mem_wstrb_i = 4'hF;
        cycle();
        bus_gnt_i = 1;
        cycle();
        chk("t2_mem_first", o_bus_addr, 32'h8000_1000);
        chk("t2_we", 32'(o_bus_we), 32'd1);
        chk("t2_if_stall_a", 32'(o_if_stall), 32'd1);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0;
        cycle();
        chk("t2_mem_rv", 32'(o_mem_rv), 32'd1);
        chk("t2_if_stall_b", 32'(o_if_stall), 32'd1);
        mem_req_i = 0; mem_we_i = 0; bus_rvalid_i = 0;
        cycle();
        chk("t2_if_stall_c", 32'(o_if_stall), 32'd1);
        bus_gnt_i = 1;
        cycle();
        chk("t2_if_granted", 32'(o_bus_req), 32'd1);
        chk("t2_if_addr", o_bus_addr, 32'h8000_0004);
        chk("t2_if_we", 32'(o_bus_we), 32'd0);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_0013;
        cycle();
        chk("t2_if_rv", 32'(o_if_rv), 32'd1);
        if_req_i = 0; bus_rvalid_i = 0;
        cycle();

        // 3: flush while in RESP drops the stale fetch
        if_req_i = 1; if_addr_i = 32'h8000_0100;
        cycle();
        bus_gnt_i = 1;
        cycle();
        bus_gnt_i = 0; if_flush_i = 1;
        cycle();
        if_flush_i = 0; if_addr_i = 32'h8000_0200;
        bus_rvalid_i = 1; bus_rdata_i = 32'h1234_5678;
        cycle();
        chk("t3_dropped", 32'(o_if_rv), 32'd0);
        bus_rvalid_i = 0;
        cycle();
        chk("t3_idle", 32'(o_bus_req), 32'd0);
        bus_gnt_i = 1;
        cycle();
        chk("t3_new_addr", o_bus_addr, 32'h8000_0200);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hCAFE_0001;
        cycle();
        chk("t3_new_rv", 32'(o_if_rv), 32'd1);
        chk("t3_new_data", o_if_rdata, 32'hCAFE_0001);
        if_req_i = 0; bus_rvalid_i = 0;
        cycle();

        // 4: grant withheld for 5 cycles
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h8000_2000;
        mem_wdata_i = 32'hA5A5_5A5A; mem_wstrb_i = 4'h3;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_req_hold", 32'(o_bus_req), 32'd1);
            chk("t4_addr_hold", o_bus_addr, 32'h8000_2000);
            chk("t4_wdata_hold", o_bus_wdata, 32'hA5A5_5A5A);
        end
        bus_gnt_i = 1;
        cycle();
        chk("t4_req_6th", 32'(o_bus_req), 32'd1);
        bus_gnt_i = 0; bus_rvalid_i = 1;
        cycle();
        chk("t4_done", 32'(o_mem_rv), 32'd1);
        mem_req_i = 0; mem_we_i = 0; bus_rvalid_i = 0;
        cycle();

        // 5: load whose response never arrives
        mem_req_i = 1; mem_addr_i = 32'h8000_3000;
        cycle();
        for (int k = 1; k <= TMO; k++) begin
            bus_gnt_i = (k == 1);
            cycle();
            if (k < TMO) chk("t5_no_early_rv", 32'(o_mem_rv), 32'd0);
        end
        chk("t5_abort_rv", 32'(o_mem_rv), 32'd1);
        chk("t5_abort_data", o_mem_rdata, 32'd0);
        bus_gnt_i = 0; mem_addr_i = 32'h8000_3004;
        cycle();
        chk("t5_to_set", 32'(o_to), 32'd1);
        bus_gnt_i = 1;
        cycle();
        chk("t5_next_addr", o_bus_addr, 32'h8000_3004);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_55AA;
        cycle();
        chk("t5_next_rv", 32'(o_mem_rv), 32'd1);
        chk("t5_next_data", o_mem_rdata, 32'h0000_55AA);
        chk("t5_to_sticky", 32'(o_to), 32'd1);
        mem_req_i = 0; bus_rvalid_i = 0;
        cycle();

        // 6: reset in the middle of RESP
        mem_req_i = 1; mem_addr_i = 32'h8000_4000;
        cycle();
        bus_gnt_i = 1;
        cycle();
        bus_gnt_i = 0; rst = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_0077;
        cycle();
        chk("t6_async_rv", 32'(o_mem_rv), 32'd0);
        chk("t6_async_to", 32'(o_to), 32'd0);
        rst = 1;
        cycle();
        chk("t6_late_ignored", 32'(o_mem_rv), 32'd0);
        bus_rvalid_i = 0; bus_gnt_i = 1;
        cycle();
        chk("t6_first_req", o_bus_addr, 32'h8000_4000);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h0000_0099;
        cycle();
        chk("t6_first_rv", 32'(o_mem_rv), 32'd1);
        mem_req_i = 0; bus_rvalid_i = 0;
        cycle();

        // Randomized traffic with random flushes, bus delays and timeouts
        for (int n = 0; n < 3000; n++) begin
            if (last_if_rv) begin
                if_req_i = ($urandom_range(0, 2) == 0);
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end else if (!if_req_i && $urandom_range(0, 9) < 4) begin
                if_req_i = 1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if_flush_i = if_req_i && ($urandom_range(0, 9) == 0);
            if (if_flush_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
            if (last_mem_rv || (!mem_req_i && $urandom_range(0, 9) < 3)) begin
                mem_req_i   = last_mem_rv ? ($urandom_range(0, 2) == 0) : 1'b1;
                mem_we_i    = $urandom_range(0, 1) == 1;
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
                mem_wstrb_i = 4'($urandom);
            end
            bus_gnt_i    = t_busy && !t_granted && ($urandom_range(0, 9) < 6);
            bus_rvalid_i = (t_busy && t_granted) ? ($urandom_range(0, 9) < 5)
                                                 : ($urandom_range(0, 9) == 0);
            bus_rdata_i  = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
